// File: rtl/line_window_3x3.sv
// -----------------------------------------------------------------------------
// line_window_3x3
//
// Builds a 3x3 neighbourhood window from a raster-order pixel stream. Two line
// buffers hold the previous two lines; a 3x3 register array shifts one column
// left on every accepted pixel (beat). A window is emitted for each beat whose
// position is at least (row 2, col 2), centred on pixel (row-1, col-1).
//
// Parameters:
//   DATA_WIDTH  pixel/tap width in bits
//   IMG_WIDTH   pixels per line  (3..4096)
//   IMG_HEIGHT  lines per frame  (3..4096)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    input pixel valid
//   s_ready    block accepts the pixel this cycle (= !m_valid || m_ready)
//   s_data     pixel, raster order
//   s_sof      start of frame, qualified by s_valid
//   m_valid    window valid
//   m_ready    downstream accepts the window
//   m_win      taps p11..p33, row-major, p11 in the MSBs
//   m_sof      first window of frame
//   m_eol      last window of line
//   m_eof      last window of frame
//   frame_err  one-cycle pulse on a misplaced s_sof
//
// Build option:
//   FRAME_SYNC_EN  when defined, a beat carrying s_sof is forced to position
//                  (0,0); if the counters were elsewhere, frame_err pulses.
//                  When undefined, s_sof is ignored and frame_err is 0.
// -----------------------------------------------------------------------------
module line_window_3x3 #(
   parameter int DATA_WIDTH = 26,
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic                    s_sof,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [9*DATA_WIDTH-1:0] m_win,
   output logic                    m_sof,
   output logic                    m_eol,
   output logic                    m_eof,
   output logic                    frame_err
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col_eff;
   logic [ROW_W-1:0] row_eff;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;

   logic beat;
   logic win_hit;

   logic [DATA_WIDTH-1:0] line_a [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] line_b [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;

   logic [DATA_WIDTH-1:0] p11, p12, p13;
   logic [DATA_WIDTH-1:0] p21, p22, p23;
   logic [DATA_WIDTH-1:0] p31, p32, p33;

   // s_ready depends only on registered m_valid and on m_ready, never on s_valid.
   assign s_ready = !m_valid || m_ready;
   assign beat    = s_valid && s_ready;

   // Effective position of the current pixel: with frame sync, a beat carrying
   // s_sof is treated as pixel (0,0) regardless of where the counters were.
`ifdef FRAME_SYNC_EN
   assign col_eff = s_sof ? '0 : col;
   assign row_eff = s_sof ? '0 : row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= beat && s_sof && ((col != '0) || (row != '0));
      end
   end
`else
   logic unused_sof;

   assign unused_sof = s_sof;
   assign col_eff    = col;
   assign row_eff    = row;
   assign frame_err  = 1'b0;
`endif

   always_comb begin
      col_nxt = col_eff + COL_W'(1);
      row_nxt = row_eff;
      if (col_eff == COL_LAST) begin
         col_nxt = '0;
         if (row_eff == ROW_LAST) begin
            row_nxt = '0;
         end else begin
            row_nxt = row_eff + ROW_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         col <= col_nxt;
         row <= row_nxt;
      end
   end

   // Line buffers: asynchronous read of the pre-write word, write on the beat.
   // Contents are never cleared; stale words only reach taps that are masked
   // because no window is emitted until row >= 2 and col >= 2.
   assign rd_a = line_a[col_eff];
   assign rd_b = line_b[col_eff];

   always_ff @(posedge clk) begin
      if (beat) begin
         line_a[col_eff] <= s_data;
         line_b[col_eff] <= rd_a;
      end
   end

   // Window shift: oldest column drops off the left, new column enters at the
   // right with (two lines up, one line up, current pixel).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p11 <= '0;
         p12 <= '0;
         p13 <= '0;
         p21 <= '0;
         p22 <= '0;
         p23 <= '0;
         p31 <= '0;
         p32 <= '0;
         p33 <= '0;
      end else if (beat) begin
         p11 <= p12;
         p12 <= p13;
         p13 <= rd_b;
         p21 <= p22;
         p22 <= p23;
         p23 <= rd_a;
         p31 <= p32;
         p32 <= p33;
         p33 <= s_data;
      end
   end

   assign m_win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

   assign win_hit = beat && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);

   // Flags are loaded only together with a new window, so they stay stable
   // for as long as a window is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
      end else if (win_hit) begin
         m_valid <= 1'b1;
         m_sof   <= (row_eff == ROW_TWO) && (col_eff == COL_TWO);
         m_eol   <= (col_eff == COL_LAST);
         m_eof   <= (col_eff == COL_LAST) && (row_eff == ROW_LAST);
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_line_window_3x3.sv
module tb_line_window_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 26;
   localparam int WW = 9 * DW;
   localparam int MAX_CYC = 3000;

`ifdef FRAME_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_sof;
   logic          m_valid;
   logic          m_ready;
   logic [WW-1:0] m_win;
   logic          m_sof;
   logic          m_eol;
   logic          m_eof;
   logic          frame_err;

   line_window_3x3 #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_sof     (s_sof),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_win     (m_win),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .m_eof     (m_eof),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] win;
      logic          sof;
      logic          eol;
      logic          eof;
   } win_t;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state: a picture of the frame indexed by position
   logic [DW-1:0] img [H][W];
   int            mr, mc;
   win_t          exp_q [$];
   logic [WW-1:0] got_q [$];
   logic          last_eof;
   bit            err_arm;
   int            err_seen;
   bit            stall_prev;
   logic [WW-1:0] prev_win;

   logic [DW-1:0] pix_q [$];
   bit            sof_q [$];

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_beat(input logic [DW-1:0] d, input bit sof);
      win_t w;
      if (SYNC && sof) begin
         if (mr != 0 || mc != 0) err_arm = 1'b1;
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
         w.win = '0;
         for (int i = 0; i < 9; i++)
            w.win[(8-i)*DW +: DW] = img[mr-2+i/3][mc-2+i%3];
         w.sof = (mr == 2 && mc == 2);
         w.eol = (mc == W-1);
         w.eof = (mr == H-1 && mc == W-1);
         exp_q.push_back(w);
      end
      mc++;
      if (mc == W) begin
         mc = 0;
         mr++;
         if (mr == H) mr = 0;
      end
   endtask

   task automatic load_ramp(input int n, input int offset);
      for (int k = 0; k < n; k++) begin
         pix_q.push_back(DW'((8 * (k / W) + (k % W)) % 48 + offset));
         sof_q.push_back(k == 0);
      end
   endtask

   // ready_mode: 0 = always 1, 1 = toggle each cycle, 2 = random
   task automatic run(input int ready_mode, input int gap_pct, input int drain);
      int cyc;
      int idle;
      win_t e;
      cyc  = 0;
      idle = 0;
      while ((pix_q.size() > 0 || idle < drain) && cyc < MAX_CYC) begin
         @(negedge clk);
         cyc++;
         chk("frame_err", WW'(frame_err), WW'(err_arm));
         if (frame_err) err_seen++;
         err_arm = 1'b0;
         if (stall_prev) begin
            chk("stall_valid", WW'(m_valid), WW'(1));
            chk("stall_win", m_win, prev_win);
         end
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 2 == 0);
            default: m_ready = ($urandom_range(99) < 60);
         endcase
         if (pix_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            s_valid = 1'b1;
            s_data  = pix_q[0];
            s_sof   = sof_q[0];
         end else begin
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            s_sof   = 1'($urandom_range(1));
         end
         #1;
         chk("s_ready", WW'(s_ready), WW'(!(m_valid && !m_ready)));
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_window", WW'(1), WW'(0));
            end else begin
               e = exp_q.pop_front();
               chk("m_win", m_win, e.win);
               chk("m_sof", WW'(m_sof), WW'(e.sof));
               chk("m_eol", WW'(m_eol), WW'(e.eol));
               chk("m_eof", WW'(m_eof), WW'(e.eof));
            end
            got_q.push_back(m_win);
            last_eof = m_eof;
         end
         stall_prev = m_valid && !m_ready;
         prev_win   = m_win;
         if (s_valid && s_ready) begin
            model_beat(s_data, s_sof);
            void'(pix_q.pop_front());
            void'(sof_q.pop_front());
         end
         if (pix_q.size() == 0) idle++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      chk("run_timeout", WW'(cyc < MAX_CYC), WW'(1));
      chk("leftover_windows", WW'(exp_q.size()), WW'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", WW'(m_valid), WW'(0));
      chk("rst_s_ready", WW'(s_ready), WW'(1));
      chk("rst_m_win", m_win, WW'(0));
      chk("rst_flags", WW'({m_sof, m_eol, m_eof, frame_err}), WW'(0));
      repeat (2) @(negedge clk);
      chk("rst_hold_valid", WW'(m_valid), WW'(0));
      rst_n      = 1'b1;
      exp_q.delete();
      mr         = 0;
      mc         = 0;
      err_arm    = 1'b0;
      stall_prev = 1'b0;
   endtask

   initial begin
      logic [WW-1:0] exp1;
      logic [WW-1:0] exp2;
      logic [WW-1:0] tmp;
      int taps [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_sof   = 1'b0;
      m_ready = 1'b1;
      err_seen = 0;
      for (int i = 0; i < 9; i++) begin
         exp1[(8-i)*DW +: DW] = DW'(taps[i]);
         exp2[(8-i)*DW +: DW] = DW'(taps[i] + 100);
      end

      do_reset();

      // single frame, ramp data, downstream always ready
      got_q.delete();
      load_ramp(48, 0);
      run(0, 0, 10);
      chk("t1_count", WW'(got_q.size()), WW'(24));
      if (got_q.size() == 24) begin
         chk("t1_first", got_q[0], exp1);
         tmp = got_q[23];
         chk("t1_last_p33", WW'(tmp[DW-1:0]), WW'(47));
         chk("t1_last_eof", WW'(last_eof), WW'(1));
      end

      // full-rate input, downstream ready toggling
      got_q.delete();
      load_ramp(48, 0);
      run(1, 0, 20);
      chk("t2_count", WW'(got_q.size()), WW'(24));

      // two back-to-back frames, second offset by 100
      got_q.delete();
      load_ramp(48, 0);
      load_ramp(48, 100);
      run(0, 0, 10);
      chk("t3_count", WW'(got_q.size()), WW'(48));
      if (got_q.size() == 48) chk("t3_frame2_first", got_q[24], exp2);

      // reset mid-frame after 20 beats, then a full frame
      load_ramp(20, 0);
      run(0, 0, 5);
      do_reset();
      got_q.delete();
      load_ramp(48, 0);
      run(0, 0, 10);
      chk("t4_count", WW'(got_q.size()), WW'(24));
      if (got_q.size() == 24) chk("t4_first", got_q[0], exp1);

      // random data, random input gaps, random backpressure, two frames
      got_q.delete();
      for (int k = 0; k < 96; k++) begin
         pix_q.push_back(DW'($urandom));
         sof_q.push_back(k % 48 == 0);
      end
      run(2, 30, 40);
      chk("t5_count", WW'(got_q.size()), WW'(48));

      // misplaced s_sof on beat 13, then 48 more beats from it
      got_q.delete();
      err_seen = 0;
      for (int k = 0; k < 61; k++) begin
         pix_q.push_back(DW'($urandom));
         sof_q.push_back(k == 13);
      end
      run(0, 0, 10);
      chk("t6_count", WW'(got_q.size()), WW'(24));
      chk("t6_err_pulses", WW'(err_seen), WW'(SYNC ? 1 : 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
